prng_reseed_ctrl: RTL

Seed-loading controller that drives the feed side of the masked-core PRNG unit. It takes a 128-bit seed as a stream of SIZE_FEED-bit words over a valid/ready handshake and turns it into the PRNG's `feed` / `lock_feed` / `feed_data` / `pre_rst` sequence. It then runs the LFSR through a warm-up phase and hands `pre_enable_run` back to the core once fresh randomness is valid. It sits between the top-level seed/key interface and the PRNG, beside the Clyde datapath controller.

---
 rtl/prng_reseed_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prng_reseed_ctrl.sv
// Seed-loading controller for the masked-core PRNG: streams a 128-bit seed into
// the PRNG feed port, pulses pre_rst, warms up the LFSR, then hands over run control.
module prng_reseed_ctrl #(
  parameter int unsigned SIZE_FEED   = 32,
  parameter int unsigned WARM_CYCLES = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reseed_req,
  input  logic                 seed_valid,
  input  logic [SIZE_FEED-1:0] seed_data,
  output logic                 seed_ready,
  input  logic                 run_req,
  input  logic                 rnd_valid_next_enable,
  output logic                 pre_enable_run,
  output logic                 lock_feed,
  output logic                 feed,
  output logic [SIZE_FEED-1:0] feed_data,
  output logic                 pre_rst,
  output logic                 prng_ready,
  output logic                 busy
);

  localparam int unsigned SEED_WORDS = 128 / SIZE_FEED;
  localparam int unsigned WORD_CW    = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;
  localparam int unsigned WARM_CW    = $clog2(WARM_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RST   = 3'd3,
    WARM  = 3'd4,
    READY = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_CW-1:0]   word_cnt_q, word_cnt_d;
  logic [WARM_CW-1:0]   warm_cnt_q, warm_cnt_d;
  logic                 feed_q, feed_d;
  logic [SIZE_FEED-1:0] feed_data_q, feed_data_d;
  logic                 pre_rst_q, pre_rst_d;
  logic                 lock_feed_q, lock_feed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      warm_cnt_q  <= '0;
      feed_q      <= 1'b0;
      feed_data_q <= '0;
      pre_rst_q   <= 1'b0;
      lock_feed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      feed_q      <= feed_d;
      feed_data_q <= feed_data_d;
      pre_rst_q   <= pre_rst_d;
      lock_feed_q <= lock_feed_d;
    end
  end

  // Next state; the PRNG-facing strobes are computed from the next state so they come from flops.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    feed_d      = 1'b0;
    feed_data_d = feed_data_q;
    unique case (state_q)
      IDLE, READY: begin
        if (reseed_req) begin
          state_d    = LOAD;
          word_cnt_d = '0;
        end
      end
      LOAD: begin
        if (seed_valid) begin
          feed_d      = 1'b1;
          feed_data_d = seed_data;
          if (word_cnt_q == WORD_CW'(SEED_WORDS - 1)) begin
            word_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            word_cnt_d = word_cnt_q + WORD_CW'(1);
          end
        end
      end
      DRAIN: state_d = RST;
      RST: begin
        state_d    = WARM;
        warm_cnt_d = '0;
      end
      WARM: begin
        if (warm_cnt_q < WARM_CW'(WARM_CYCLES)) begin
          warm_cnt_d = warm_cnt_q + WARM_CW'(1);
        end
        if ((warm_cnt_q >= WARM_CW'(WARM_CYCLES)) && rnd_valid_next_enable) begin
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
    lock_feed_d = (state_d == LOAD) || (state_d == DRAIN);
    pre_rst_d   = (state_d == RST);
  end

  assign feed           = feed_q;
  assign feed_data      = feed_data_q;
  assign pre_rst        = pre_rst_q;
  assign lock_feed      = lock_feed_q;
  assign seed_ready     = (state_q == LOAD);
  assign busy           = (state_q == LOAD) || (state_q == DRAIN) ||
                          (state_q == RST)  || (state_q == WARM);
  assign prng_ready     = (state_q == READY);
  assign pre_enable_run = (state_q == WARM) || ((state_q == READY) && run_req);

endmodule
